// File: rtl/ddr100_phy_rd_align_if.sv
// ddr100_phy_rd_align_if
//   Bundle between the read-path aligner and its controller/deserialiser side.
//   master : drives the oversampled DQS/DQ words, rd_issue and cal_start,
//            observes calibration status and aligned read data.
//   slave  : the aligner itself (ddr100_phy_rd_align).
//
//   dqs_smp    8 DQS samples per core cycle, bit 0 earliest
//   dq_smp     8 samples per DQ bit, bits [8i+7:8i] belong to DQ i
//   rd_issue   one-cycle pulse, a BL4 read was issued this cycle
//   cal_start  pulse, start or restart calibration
//   cal_rd_req calibration wants the controller to issue a read
//   cal_done   calibration passed, rd_lat/tap valid
//   cal_fail   calibration gave up
//   rd_lat     calibrated read latency in core cycles
//   tap        calibrated DQS edge sample position
//   rdata_p0/1 first/second beat of the current cycle
//   rvalid     rdata_p0/p1 valid
interface ddr100_phy_rd_align_if #(
    parameter int DQ_W = 8
);
    logic [7:0]        dqs_smp;
    logic [8*DQ_W-1:0] dq_smp;
    logic              rd_issue;
    logic              cal_start;
    logic              cal_rd_req;
    logic              cal_done;
    logic              cal_fail;
    logic [3:0]        rd_lat;
    logic [2:0]        tap;
    logic [DQ_W-1:0]   rdata_p0;
    logic [DQ_W-1:0]   rdata_p1;
    logic              rvalid;

    modport master (
        output dqs_smp, dq_smp, rd_issue, cal_start,
        input  cal_rd_req, cal_done, cal_fail, rd_lat, tap,
               rdata_p0, rdata_p1, rvalid
    );

    modport slave (
        input  dqs_smp, dq_smp, rd_issue, cal_start,
        output cal_rd_req, cal_done, cal_fail, rd_lat, tap,
               rdata_p0, rdata_p1, rvalid
    );
endinterface

// File: rtl/ddr100_phy_rd_align.sv
// ddr100_phy_rd_align
//   Read capture and alignment for one DDR byte lane of the 100 MHz PHY.
//   Calibrates read latency and DQS sampling phase from the first DQS rising
//   edge seen after a read, then extracts two beats per core cycle.
//
//   Ports:
//     clk100m_i  PHY core clock, all logic on its rising edge
//     phy_rst_i  synchronous active-high reset
//     bus        ddr100_phy_rd_align_if.slave (samples in, status/data out)
//
//   Build option:
//     DDR100_RD_MAJORITY_EN  each beat is the 2-of-3 majority around its
//                            centre sample instead of the single centre sample.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | out of reset, waiting for cal_start
//   S_WAIT_RD| asking the controller for a calibration read
//   S_SEARCH | counting cycles since the read, looking for a DQS edge
//   S_DONE   | calibrated, data path live
//   S_FAIL   | four failed tries, waiting for cal_start
module ddr100_phy_rd_align #(
    parameter int DQ_W   = 8,
    parameter int RL_MAX = 15
) (
    input  logic                   clk100m_i,
    input  logic                   phy_rst_i,
    ddr100_phy_rd_align_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_RD = 3'd1;
    localparam logic [2:0] S_SEARCH  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    localparam logic [3:0] RL_MAX_C = 4'(RL_MAX);
    localparam int         SR_W     = RL_MAX + 3;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        tries_q, tries_d;
    logic              have_first_q, have_first_d;
    logic [3:0]        first_lat_q, first_lat_d;
    logic [2:0]        first_tap_q, first_tap_d;
    logic              commit;

    logic              prev_dqs7_q;
    logic [8:0]        dqs_win;
    logic              edge_found;
    logic [2:0]        edge_pos;

    logic [2:0]        tries_inc;
    logic [2:0]        retry_state;

    logic              cal_rd_req_q;
    logic              cal_done_q;
    logic              cal_fail_q;
    logic [3:0]        rd_lat_q;
    logic [2:0]        tap_q;

    logic [SR_W-1:0]   rd_sr_q, rd_sr_d;
    logic [8*DQ_W-1:0] dq_dly_q;
    logic              in_done;
    logic              rvalid_q, rvalid_d;
    logic              rd_hit;
    logic [4:0]        lat_a, lat_b;
    logic [3:0]        ctr_p0, ctr_p1;
    logic [DQ_W-1:0]   rdata_p0_q, rdata_p0_d;
    logic [DQ_W-1:0]   rdata_p1_q, rdata_p1_d;

    // Window bit 0 is the last sample of the previous cycle so an edge that
    // straddles the cycle boundary reports position 0.
    assign dqs_win = {bus.dqs_smp, prev_dqs7_q};

    always_comb begin
        edge_found = 1'b0;
        edge_pos   = 3'd0;
        // Scan downward so the lowest qualifying index wins.
        for (int i = 7; i >= 0; i--) begin
            if (dqs_win[i+1] && !dqs_win[i]) begin
                edge_found = 1'b1;
                edge_pos   = 3'(i);
            end
        end
    end

    assign tries_inc   = tries_q + 3'd1;
    assign retry_state = (tries_inc == 3'd4) ? S_FAIL : S_WAIT_RD;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tries_d      = tries_q;
        have_first_d = have_first_q;
        first_lat_d  = first_lat_q;
        first_tap_d  = first_tap_q;
        commit       = 1'b0;
        if (bus.cal_start) begin
            state_d      = S_WAIT_RD;
            tries_d      = 3'd0;
            have_first_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_RD: begin
                    if (bus.rd_issue) begin
                        state_d = S_SEARCH;
                        cnt_d   = 4'd1;
                    end
                end
                S_SEARCH: begin
                    if (edge_found) begin
                        if (!have_first_q) begin
                            first_lat_d  = cnt_q;
                            first_tap_d  = edge_pos;
                            have_first_d = 1'b1;
                            state_d      = S_WAIT_RD;
                        end else if (first_lat_q == cnt_q && first_tap_q == edge_pos) begin
                            commit  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            first_lat_d = cnt_q;
                            first_tap_d = edge_pos;
                            tries_d     = tries_inc;
                            state_d     = retry_state;
                        end
                    end else if (cnt_q == RL_MAX_C) begin
                        tries_d = tries_inc;
                        state_d = retry_state;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_IDLE, S_DONE, S_FAIL: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Reads only count while DONE is held across the cycle; leaving DONE
    // (cal_start) flushes everything in flight.
    assign in_done = (state_q == S_DONE) && (state_d == S_DONE);
    assign rd_sr_d = in_done ? {rd_sr_q[SR_W-2:0], bus.rd_issue} : '0;

    // rd_sr_q[k] is high k+1 cycles after the issue; registering the hit
    // puts rvalid on issue+rd_lat+2 and issue+rd_lat+3.
    assign lat_a = {1'b0, rd_lat_q};
    assign lat_b = lat_a + 5'd1;

    always_comb begin
        rd_hit = 1'b0;
        for (int k = 0; k < SR_W; k++) begin
            if (5'(k) == lat_a || 5'(k) == lat_b) begin
                rd_hit = rd_hit | rd_sr_q[k];
            end
        end
    end

    assign rvalid_d = in_done && rd_hit;

    // Beat centres sit two samples after each DQS transition; the delayed
    // word holds window indices 0..7, the live word 8..15.
    assign ctr_p0 = {1'b0, tap_q} + 4'd2;
    assign ctr_p1 = {1'b0, tap_q} + 4'd6;

    function automatic logic beat_pick(input logic [15:0] w, input logic [3:0] c);
`ifdef DDR100_RD_MAJORITY_EN
        logic s_lo;
        logic s_mid;
        logic s_hi;
        s_lo  = w[c - 4'd1];
        s_mid = w[c];
        s_hi  = w[c + 4'd1];
        return (s_lo & s_mid) | (s_lo & s_hi) | (s_mid & s_hi);
`else
        return w[c];
`endif
    endfunction

    always_comb begin
        rdata_p0_d = '0;
        rdata_p1_d = '0;
        for (int j = 0; j < DQ_W; j++) begin
            rdata_p0_d[j] = beat_pick({bus.dq_smp[8*j +: 8], dq_dly_q[8*j +: 8]}, ctr_p0);
            rdata_p1_d[j] = beat_pick({bus.dq_smp[8*j +: 8], dq_dly_q[8*j +: 8]}, ctr_p1);
        end
    end

    always_ff @(posedge clk100m_i) begin
        if (phy_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            tries_q      <= 3'd0;
            have_first_q <= 1'b0;
            first_lat_q  <= 4'd0;
            first_tap_q  <= 3'd0;
            prev_dqs7_q  <= 1'b0;
            cal_rd_req_q <= 1'b0;
            cal_done_q   <= 1'b0;
            cal_fail_q   <= 1'b0;
            rd_lat_q     <= 4'd0;
            tap_q        <= 3'd0;
            rd_sr_q      <= '0;
            dq_dly_q     <= '0;
            rvalid_q     <= 1'b0;
            rdata_p0_q   <= '0;
            rdata_p1_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            have_first_q <= have_first_d;
            first_lat_q  <= first_lat_d;
            first_tap_q  <= first_tap_d;
            prev_dqs7_q  <= bus.dqs_smp[7];
            cal_rd_req_q <= (state_d == S_WAIT_RD);
            cal_done_q   <= (state_d == S_DONE);
            cal_fail_q   <= (state_d == S_FAIL);
            if (commit) begin
                rd_lat_q <= cnt_q;
                tap_q    <= edge_pos;
            end
            rd_sr_q  <= rd_sr_d;
            dq_dly_q <= bus.dq_smp;
            rvalid_q <= rvalid_d;
            if (state_q == S_DONE) begin
                rdata_p0_q <= rdata_p0_d;
                rdata_p1_q <= rdata_p1_d;
            end
        end
    end

    assign bus.cal_rd_req = cal_rd_req_q;
    assign bus.cal_done   = cal_done_q;
    assign bus.cal_fail   = cal_fail_q;
    assign bus.rd_lat     = rd_lat_q;
    assign bus.tap        = tap_q;
    assign bus.rdata_p0   = rdata_p0_q;
    assign bus.rdata_p1   = rdata_p1_q;
    assign bus.rvalid     = rvalid_q;

endmodule

// File: tb/tb_ddr100_phy_rd_align.sv
// Bench for ddr100_phy_rd_align. A virtual DRAM writes each read burst into a
// per-sample DQS/DQ stream (preamble low, rising edge at (issue+L)*8+e, four
// beats of four samples); expected rvalid/beats are derived from the same
// burst description. Only the centre sample of each beat carries the beat
// value (neighbours are random), so a wrong centre index shows up as bad data.
module tb_ddr100_phy_rd_align;
    localparam int DQ_W   = 8;
    localparam int RL_MAX = 15;
    localparam int NCYC   = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr100_phy_rd_align_if #(.DQ_W(DQ_W)) bus ();

    ddr100_phy_rd_align #(.DQ_W(DQ_W), .RL_MAX(RL_MAX)) dut (
        .clk100m_i (clk),
        .phy_rst_i (rst),
        .bus       (bus)
    );

    logic [7:0]        dqs_cyc [NCYC];
    logic [8*DQ_W-1:0] dq_cyc  [NCYC];
    bit                exp_rv  [NCYC];
    logic [DQ_W-1:0]   exp_p0  [NCYC];
    logic [DQ_W-1:0]   exp_p1  [NCYC];

    int cyc;
    int n_pass;
    int n_chk;
    bit chk_en;
    bit model_done;
    int l_cal;
    int e_cal;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic kill_future();
        for (int k = cyc + 1; k < NCYC; k++) exp_rv[k] = 1'b0;
    endtask

    task automatic put_sample(input int s, input logic dqs_v, input logic [DQ_W-1:0] dq_v);
        int c;
        int k;
        c = s / 8;
        k = s % 8;
        if (c < NCYC) begin
            dqs_cyc[c][k] = dqs_v;
            for (int j = 0; j < DQ_W; j++) dq_cyc[c][8*j+k] = dq_v[j];
        end
    endtask

    task automatic burst(input int ci, input int lat, input int e, input logic [4*DQ_W-1:0] beats);
        int s0;
        logic [DQ_W-1:0] bv;
        logic [DQ_W-1:0] v;
        s0 = (ci + lat) * 8 + e;
        for (int b = 0; b < 4; b++) begin
            bv = beats[b*DQ_W +: DQ_W];
            for (int k = 0; k < 4; k++) begin
                v = DQ_W'($urandom);
`ifdef DDR100_RD_MAJORITY_EN
                // neighbours hold the beat, the centre carries random glitches
                if (k == 1 || k == 3) v = bv;
                else if (k == 2) v = bv ^ DQ_W'($urandom);
`else
                if (k == 2) v = bv;
`endif
                put_sample(s0 + 4*b + k, ((b % 2) == 0), v);
            end
        end
    endtask

    task automatic expect_read(input int ci, input int lat, input logic [4*DQ_W-1:0] beats);
        if (ci + lat + 3 < NCYC) begin
            exp_rv[ci+lat+2] = 1'b1;
            exp_p0[ci+lat+2] = beats[0*DQ_W +: DQ_W];
            exp_p1[ci+lat+2] = beats[1*DQ_W +: DQ_W];
            exp_rv[ci+lat+3] = 1'b1;
            exp_p0[ci+lat+3] = beats[2*DQ_W +: DQ_W];
            exp_p1[ci+lat+3] = beats[3*DQ_W +: DQ_W];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NCYC - 40) begin
            $display("FAIL cycle_budget: got %0d want < %0d", cyc, NCYC - 40);
            $fatal(1, "cycle budget exhausted");
        end
        if (chk_en) begin
            chk("rvalid", 32'(bus.rvalid), 32'(exp_rv[cyc]));
            if (exp_rv[cyc]) begin
                chk("rdata_p0", 32'(bus.rdata_p0), 32'(exp_p0[cyc]));
                chk("rdata_p1", 32'(bus.rdata_p1), 32'(exp_p1[cyc]));
            end
        end
        bus.dqs_smp   = dqs_cyc[cyc];
        bus.dq_smp    = dq_cyc[cyc];
        bus.rd_issue  = 1'b0;
        bus.cal_start = 1'b0;
        rst           = 1'b0;
    endtask

    function automatic logic [4*DQ_W-1:0] rnd_beats();
        return (4*DQ_W)'($urandom);
    endfunction

    task automatic rd(input int lat, input int e, input bit dqs_on, input logic [4*DQ_W-1:0] beats);
        if (dqs_on) burst(cyc, lat, e, beats);
        if (model_done) expect_read(cyc, lat, beats);
        bus.rd_issue = 1'b1;
    endtask

    task automatic start_cal();
        model_done    = 1'b0;
        bus.cal_start = 1'b1;
        kill_future();
        step();
        chk("cal_done_drop", 32'(bus.cal_done), 32'd0);
        chk("cal_fail_drop", 32'(bus.cal_fail), 32'd0);
        repeat (20) step();
    endtask

    task automatic calibrate(input int lat, input int e);
        start_cal();
        for (int r = 0; r < 2; r++) begin
            chk("cal_rd_req", 32'(bus.cal_rd_req), 32'd1);
            chk("cal_done_early", 32'(bus.cal_done), 32'd0);
            rd(lat, e, 1'b1, rnd_beats());
            step();
            repeat (lat + 2) step();
        end
        chk("cal_done", 32'(bus.cal_done), 32'd1);
        chk("cal_fail", 32'(bus.cal_fail), 32'd0);
        chk("rd_lat", 32'(bus.rd_lat), 32'(lat));
        chk("tap", 32'(bus.tap), 32'(e));
        chk("cal_rd_req_off", 32'(bus.cal_rd_req), 32'd0);
        l_cal      = lat;
        e_cal      = e;
        model_done = 1'b1;
    endtask

    task automatic reads(input int n);
        int sp;
        for (int i = 0; i < n; i++) begin
            rd(l_cal, e_cal, 1'b1, rnd_beats());
            step();
            sp = $urandom_range(2, 5);
            repeat (sp - 1) step();
        end
        repeat (l_cal + 6) step();
    endtask

    task automatic fail_mismatch();
        int e;
        int lat;
        e = $urandom_range(0, 7);
        start_cal();
        for (int i = 0; i < 5; i++) begin
            lat = ((i % 2) == 0) ? 4 : 6;
            chk("mm_cal_fail_pre", 32'(bus.cal_fail), 32'd0);
            chk("mm_cal_rd_req", 32'(bus.cal_rd_req), 32'd1);
            rd(lat, e, 1'b1, rnd_beats());
            step();
            repeat (lat + 2) step();
        end
        chk("mm_cal_fail", 32'(bus.cal_fail), 32'd1);
        chk("mm_cal_done", 32'(bus.cal_done), 32'd0);
        chk("mm_cal_rd_req_off", 32'(bus.cal_rd_req), 32'd0);
        // a read while failed must not produce rvalid
        rd(4, e, 1'b1, rnd_beats());
        step();
        repeat (8) step();
    endtask

    task automatic fail_timeout();
        start_cal();
        for (int i = 0; i < 4; i++) begin
            chk("to_cal_fail_pre", 32'(bus.cal_fail), 32'd0);
            chk("to_cal_rd_req", 32'(bus.cal_rd_req), 32'd1);
            rd(RL_MAX, 0, 1'b0, rnd_beats());
            step();
            repeat (RL_MAX + 2) step();
        end
        chk("to_cal_fail", 32'(bus.cal_fail), 32'd1);
        chk("to_cal_done", 32'(bus.cal_done), 32'd0);
    endtask

    initial begin
        logic [4*DQ_W-1:0] bt;
        int lat;
        int e;
        for (int c = 0; c < NCYC; c++) begin
            dqs_cyc[c] = 8'd0;
            dq_cyc[c]  = (8*DQ_W)'({$urandom, $urandom});
            exp_rv[c]  = 1'b0;
            exp_p0[c]  = '0;
            exp_p1[c]  = '0;
        end
        cyc        = 0;
        n_pass     = 0;
        n_chk      = 0;
        chk_en     = 1'b0;
        model_done = 1'b0;
        l_cal      = 0;
        e_cal      = 0;

        // reset held three cycles with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dqs_smp   = 8'($urandom);
            bus.dq_smp    = (8*DQ_W)'({$urandom, $urandom});
            bus.rd_issue  = 1'($urandom);
            bus.cal_start = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_cal_rd_req", 32'(bus.cal_rd_req), 32'd0);
        chk("rst_cal_done", 32'(bus.cal_done), 32'd0);
        chk("rst_cal_fail", 32'(bus.cal_fail), 32'd0);
        chk("rst_rd_lat", 32'(bus.rd_lat), 32'd0);
        chk("rst_tap", 32'(bus.tap), 32'd0);
        chk("rst_rdata_p0", 32'(bus.rdata_p0), 32'd0);
        chk("rst_rdata_p1", 32'(bus.rdata_p1), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        rst           = 1'b0;
        bus.dqs_smp   = dqs_cyc[cyc];
        bus.dq_smp    = dq_cyc[cyc];
        bus.rd_issue  = 1'b0;
        bus.cal_start = 1'b0;
        chk_en        = 1'b1;

        // IDLE ignores reads
        repeat (3) begin
            bus.rd_issue = 1'($urandom);
            step();
        end
        chk("idle_cal_rd_req", 32'(bus.cal_rd_req), 32'd0);
        chk("idle_cal_done", 32'(bus.cal_done), 32'd0);

        calibrate(5, 3);

        // aligned read: DQ0 beats 1,0,1,1
        bt = rnd_beats();
        bt[0]      = 1'b1;
        bt[DQ_W]   = 1'b0;
        bt[2*DQ_W] = 1'b1;
        bt[3*DQ_W] = 1'b1;
        rd(5, 3, 1'b1, bt);
        step();
        repeat (9) step();

        // back-to-back reads two cycles apart
        rd(l_cal, e_cal, 1'b1, rnd_beats());
        step();
        step();
        rd(l_cal, e_cal, 1'b1, rnd_beats());
        step();
        repeat (10) step();

        reads(20);

        // cal_start with a read in flight: the read is discarded
        rd(l_cal, e_cal, 1'b1, rnd_beats());
        step();
        step();
        lat = $urandom_range(2, 12);
        e   = $urandom_range(0, 7);
        calibrate(lat, e);
        reads(10);

        calibrate(RL_MAX, 7);
        reads(8);
        calibrate(2, 0);
        reads(8);

        // reset on the first rvalid cycle of a read
        rd(l_cal, e_cal, 1'b1, rnd_beats());
        step();
        repeat (l_cal + 1) step();
        rst        = 1'b1;
        model_done = 1'b0;
        kill_future();
        step();
        chk("mid_rst_cal_done", 32'(bus.cal_done), 32'd0);
        chk("mid_rst_rd_lat", 32'(bus.rd_lat), 32'd0);
        repeat (5) step();

        lat = $urandom_range(2, 12);
        e   = $urandom_range(0, 7);
        calibrate(lat, e);
        reads(6);

        fail_mismatch();
        fail_timeout();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
